// File: rtl/mult_shift_add_n_pkg.sv
// Shared types for the shift-and-add multiplier family.
package mult_shift_add_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_SIGN,
        ST_END
    } estado_mult_n_t;

endpackage

// File: rtl/mult_shift_add_n_controlador.sv
// Sequencing FSM and iteration counter for mult_shift_add_n.
//   state   | meaning
//   ST_IDLE | waiting for en_i; operands loaded on the start edge
//   ST_CALC | one shift-and-add iteration per cycle
//   ST_SIGN | conditional two's-complement negation of the product
//   ST_END  | product valid, fim_o pulse
module controlador_mult_n
    import mult_shift_add_n_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           strt_cmpt_i,
    input  logic           b_zero_i,
    output estado_mult_n_t state_o
);

    localparam int CW = $clog2(WIDTH);

    estado_mult_n_t state, state_nxt;
    logic [CW-1:0]  cnt;
    logic           calc_done;

    assign calc_done = (cnt == CW'(WIDTH - 1)) || (EARLY_EXIT && b_zero_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (state == ST_IDLE && strt_cmpt_i) begin
            cnt <= '0;
        end else if (state == ST_CALC) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (strt_cmpt_i) state_nxt = ST_CALC;
            ST_CALC: if (calc_done)   state_nxt = ST_SIGN;
            ST_SIGN: state_nxt = ST_END;
            ST_END:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        state_o = state;
    end

endmodule

// File: rtl/mult_shift_add_n.sv
// Sequential shift-and-add multiplier, unsigned or two's complement per operation.
module mult_shift_add_n
    import mult_shift_add_n_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   A_i,
    input  logic [WIDTH-1:0]   B_i,
    output logic [2*WIDTH-1:0] Y_o,
    output logic               busy_o,
    output logic               fim_o
);

    estado_mult_n_t     state;
    logic [2*WIDTH-1:0] a_q, y_q;
    logic [WIDTH-1:0]   b_q;
    logic               neg_q;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               b_zero;

    // Magnitudes stay unsigned in WIDTH bits; -2^(WIDTH-1) maps to 2^(WIDTH-1).
    assign a_mag  = (signed_i && A_i[WIDTH-1]) ? -A_i : A_i;
    assign b_mag  = (signed_i && B_i[WIDTH-1]) ? -B_i : B_i;
    assign b_zero = (b_q[WIDTH-1:1] == '0);

    controlador_mult_n #(
        .WIDTH      (WIDTH),
        .EARLY_EXIT (EARLY_EXIT)
    ) u_ctrl (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .strt_cmpt_i (en_i),
        .b_zero_i    (b_zero),
        .state_o     (state)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            y_q   <= '0;
            neg_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en_i) begin
                        a_q   <= {{WIDTH{1'b0}}, a_mag};
                        b_q   <= b_mag;
                        y_q   <= '0;
                        neg_q <= signed_i & (A_i[WIDTH-1] ^ B_i[WIDTH-1]);
                    end
                end
                ST_CALC: begin
                    if (b_q[0]) y_q <= y_q + a_q;
                    a_q <= a_q << 1;
                    b_q <= b_q >> 1;
                end
                ST_SIGN: begin
                    if (neg_q) y_q <= -y_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign Y_o    = y_q;
    assign busy_o = (state != ST_IDLE);
    assign fim_o  = (state == ST_END);

endmodule
